// File: rtl/mio_bus_responder.sv
// ---------------------------------------------------------------------------
// mio_bus_responder
//
// Purpose:
//   Single-master memory/IO responder. It accepts one CPU request at a time,
//   inserts WAIT_CYCLES wait states, then gives a one-cycle response. The
//   address space holds a word RAM, a 16-bit LED register and a free-running
//   32-bit cycle counter. Misaligned or unmapped accesses get err with the
//   response and have no side effects.
//
// Parameters:
//   DEPTH_LOG2   RAM holds 2^DEPTH_LOG2 32-bit words starting at address 0
//   WAIT_CYCLES  wait states before each response (0..15)
//   PERIPH_BASE  LED register at +0x0, cycle counter at +0x4
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-low reset
//   CPU_MIO    in   1   request valid, held until MIO_ready
//   mem_w      in   1   1 = write, 0 = read
//   Addr_in    in  32   byte address
//   Data_wr    in  32   write data
//   Data_rd    out 32   read data, non-zero only during the response cycle
//   MIO_ready  out  1   one-cycle response strobe
//   err        out  1   misaligned/unmapped flag, valid with MIO_ready
//   led_out    out 16   LED register contents
// ---------------------------------------------------------------------------
module mio_bus_responder #(
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] PERIPH_BASE = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_wr,
    output logic [31:0] Data_rd,
    output logic        MIO_ready,
    output logic        err,
    output logic [15:0] led_out
);

    localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
    localparam logic [32:0] RAM_BYTES = 33'(WORDS) << 2;
    localparam logic [31:0] LED_ADDR  = PERIPH_BASE;
    localparam logic [31:0] CNT_ADDR  = PERIPH_BASE + 32'd4;
    localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [31:0] cycleCnt_q;
    logic [31:0] cntSample_q;
    logic [15:0] led_q;
    logic [31:0] mem_q [WORDS];

    logic                  accept;
    logic                  enterResp;
    logic [31:0]           txAddr;
    logic [31:0]           txWdata;
    logic                  txWrite;
    logic                  txMisaligned;
    logic                  txLed;
    logic                  txCnt;
    logic                  txRam;
    logic                  txErr;
    logic                  commit;
    logic [DEPTH_LOG2-1:0] ramIdx;

    // Next-state logic. The wait counter restarts on every accept and keeps
    // counting through WAIT; only its value against WAIT_LAST matters.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (CPU_MIO) begin
                    waitCnt_d = 4'd0;
                    state_d   = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                waitCnt_d = waitCnt_q + 4'd1;
                if (waitCnt_q == WAIT_LAST) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept    = (state_q == IDLE) && CPU_MIO;
    assign enterResp = (state_d == RESP) && (state_q != RESP);

    // With zero wait states the commit edge is also the accept edge, so the
    // request fields come straight from the inputs while still in IDLE.
    // In every other state the latched copy is authoritative.
    assign txAddr  = (state_q == IDLE) ? Addr_in : addr_q;
    assign txWdata = (state_q == IDLE) ? Data_wr : wdata_q;
    assign txWrite = (state_q == IDLE) ? mem_w   : write_q;

    // Address decode. Peripherals win over RAM, and anything at or above the
    // RAM size that is not a peripheral is unmapped (no aliasing).
    always_comb begin
        txMisaligned = (txAddr[1:0] != 2'b00);
        txLed        = (txAddr == LED_ADDR);
        txCnt        = (txAddr == CNT_ADDR);
        txRam        = !txLed && !txCnt && ({1'b0, txAddr} < RAM_BYTES);
        txErr        = txMisaligned || !(txRam || txLed || txCnt);
    end

    assign ramIdx = txAddr[DEPTH_LOG2+1:2];
    assign commit = enterResp && txWrite && !txErr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            waitCnt_q   <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            write_q     <= 1'b0;
            cycleCnt_q  <= 32'd0;
            cntSample_q <= 32'd0;
            led_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (accept) begin
                addr_q  <= Addr_in;
                wdata_q <= Data_wr;
                write_q <= mem_w;
            end
            if (enterResp) begin
                cntSample_q <= cycleCnt_q;
            end
            if (commit && txLed) begin
                led_q <= txWdata[15:0];
            end
        end
    end

    // RAM has no reset; the reset term only blocks a write on an aborting edge.
    always_ff @(posedge clk) begin
        if (reset && commit && txRam) begin
            mem_q[ramIdx] <= txWdata;
        end
    end

    always_comb begin
        MIO_ready = (state_q == RESP);
        err       = (state_q == RESP) && txErr;
        Data_rd   = 32'd0;
        if ((state_q == RESP) && !write_q && !txErr) begin
            if (txRam) begin
                Data_rd = mem_q[ramIdx];
            end else if (txLed) begin
                Data_rd = {16'd0, led_q};
            end else if (txCnt) begin
                Data_rd = cntSample_q;
            end
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_responder
//
// Directed bench for mio_bus_responder. One instance uses one wait state and
// carries most of the traffic; a second instance with zero wait states is
// used for the back-to-back handshake with CPU_MIO held high.
// ---------------------------------------------------------------------------
module tb_mio_bus_responder;

    localparam logic [31:0] PB = 32'hF000_0000;

    logic        clk;
    logic        rstN;

    logic        cpuMio, memW;
    logic [31:0] addrIn, dataWr, dataRd;
    logic        ready, errO;
    logic [15:0] led;

    logic        cpuMio0, memW0;
    logic [31:0] addrIn0, dataWr0, dataRd0;
    logic        ready0, errO0;
    logic [15:0] led0;

    int checkCount = 0;
    int passCount  = 0;

    mio_bus_responder #(
        .DEPTH_LOG2 (6),
        .WAIT_CYCLES(1),
        .PERIPH_BASE(PB)
    ) dut (
        .clk      (clk),
        .reset    (rstN),
        .CPU_MIO  (cpuMio),
        .mem_w    (memW),
        .Addr_in  (addrIn),
        .Data_wr  (dataWr),
        .Data_rd  (dataRd),
        .MIO_ready(ready),
        .err      (errO),
        .led_out  (led)
    );

    mio_bus_responder #(
        .DEPTH_LOG2 (6),
        .WAIT_CYCLES(0),
        .PERIPH_BASE(PB)
    ) dut0 (
        .clk      (clk),
        .reset    (rstN),
        .CPU_MIO  (cpuMio0),
        .mem_w    (memW0),
        .Addr_in  (addrIn0),
        .Data_wr  (dataWr0),
        .Data_rd  (dataRd0),
        .MIO_ready(ready0),
        .err      (errO0),
        .led_out  (led0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Runs one transaction on the one-wait-state instance. The request
    // fields are scrambled right after the accept edge so that any use of
    // the live inputs instead of the latched copy shows up. lat counts
    // rising edges from the accept edge to the one that raises MIO_ready.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic errOut,
                                 output int lat, output logic readyAfter,
                                 output logic errAfter);
        @(negedge clk);
        cpuMio = 1'b1;
        memW   = wr;
        addrIn = addr;
        dataWr = wdata;
        @(posedge clk);
        #1;
        lat    = 1;
        memW   = ~wr;
        addrIn = ~addr;
        dataWr = ~wdata;
        while (!ready && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata  = dataRd;
        errOut = errO;
        cpuMio = 1'b0;
        @(posedge clk);
        #1;
        readyAfter = ready;
        errAfter   = errO;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        e, rdyA, errA;
        int          lat;
        logic [31:0] txA  [4];
        logic [31:0] txD  [4];
        logic        txW  [4];
        logic [31:0] rdv  [4];
        logic [3:0]  erv;
        logic [7:0]  pattern;
        int          p;

        rstN    = 1'b0;
        cpuMio  = 1'b0; memW  = 1'b0; addrIn  = '0; dataWr  = '0;
        cpuMio0 = 1'b0; memW0 = 1'b0; addrIn0 = '0; dataWr0 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_err",   {31'd0, errO},  32'd0);
        checkOutput("rst_data",  dataRd,         32'd0);
        checkOutput("rst_led",   {16'd0, led},   32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Seed RAM words 0 and 2
        applyStimulus(1'b1, 32'h0000_0000, 32'hA5A5_0000, rd, e, lat, rdyA, errA);
        applyStimulus(1'b1, 32'h0000_0008, 32'h1111_2222, rd, e, lat, rdyA, errA);

        // Write/read 0x10
        applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, rd, e, lat, rdyA, errA);
        checkOutput("wr10_latency", 32'(lat), 32'd2);
        checkOutput("wr10_err", {31'd0, e}, 32'd0);
        checkOutput("wr10_single_pulse", {31'd0, rdyA}, 32'd0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("rd10_latency", 32'(lat), 32'd2);
        checkOutput("rd10_data", rd, 32'h1234_5678);
        checkOutput("rd10_err", {31'd0, e}, 32'd0);

        // Last RAM word, then first address past RAM
        applyStimulus(1'b1, 32'h0000_00FC, 32'hCAFE_00FC, rd, e, lat, rdyA, errA);
        applyStimulus(1'b0, 32'h0000_00FC, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("rdFC_data", rd, 32'hCAFE_00FC);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("rd100_err", {31'd0, e}, 32'd1);

        // LED register
        applyStimulus(1'b1, PB, 32'hABCD_BEEF, rd, e, lat, rdyA, errA);
        checkOutput("led_after_write", {16'd0, led}, 32'h0000_BEEF);
        applyStimulus(1'b0, PB, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("led_read", rd, 32'h0000_BEEF);

        // Misaligned read and unmapped write
        applyStimulus(1'b0, 32'h0000_0102, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("mis_rd_err", {31'd0, e}, 32'd1);
        checkOutput("mis_rd_data", rd, 32'd0);
        checkOutput("mis_rd_err_after", {31'd0, errA}, 32'd0);
        applyStimulus(1'b1, 32'h0000_0200, 32'hDEAD_DEAD, rd, e, lat, rdyA, errA);
        checkOutput("unmap_wr_err", {31'd0, e}, 32'd1);
        checkOutput("unmap_wr_data", rd, 32'd0);
        applyStimulus(1'b1, 32'h0000_0001, 32'h7777_7777, rd, e, lat, rdyA, errA);
        checkOutput("mis_wr_err", {31'd0, e}, 32'd1);
        applyStimulus(1'b0, 32'h0000_0000, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("ram0_intact", rd, 32'hA5A5_0000);
        checkOutput("ram0_err", {31'd0, e}, 32'd0);

        // Counter write is silently ignored; next peripheral slot is unmapped
        applyStimulus(1'b1, PB + 32'd4, 32'h1234_0000, rd, e, lat, rdyA, errA);
        checkOutput("cnt_wr_err", {31'd0, e}, 32'd0);
        applyStimulus(1'b0, PB + 32'd8, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("pb8_err", {31'd0, e}, 32'd1);
        checkOutput("pb8_data", rd, 32'd0);

        // Reset in WAIT of a write to 0x8, with CPU_MIO still high
        @(negedge clk);
        cpuMio = 1'b1; memW = 1'b1; addrIn = 32'h0000_0008; dataWr = 32'h5555_5555;
        @(posedge clk);
        #1;
        checkOutput("abort_wait_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_no_ready", {31'd0, ready}, 32'd0);
        checkOutput("abort_led", {16'd0, led}, 32'd0);
        cpuMio = 1'b0;
        rstN   = 1'b1;
        // Counter: 0 at reset edge, 1 at accept edge, sampled as 1 entering RESP
        applyStimulus(1'b0, PB + 32'd4, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("cnt_restart", rd, 32'd1);
        checkOutput("cnt_restart_latency", 32'(lat), 32'd2);
        applyStimulus(1'b0, 32'h0000_0008, 32'h0, rd, e, lat, rdyA, errA);
        checkOutput("abort_ram8_kept", rd, 32'h1111_2222);

        // Counter wrap: deposit all-ones in WAIT, read back in RESP
        @(negedge clk);
        cpuMio = 1'b1; memW = 1'b0; addrIn = PB + 32'd4; dataWr = 32'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        dut.cycleCnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        checkOutput("wrap_ready", {31'd0, ready}, 32'd1);
        checkOutput("wrap_data", dataRd, 32'hFFFF_FFFF);
        checkOutput("wrap_err", {31'd0, errO}, 32'd0);
        checkOutput("wrap_counter", dut.cycleCnt_q, 32'd0);
        cpuMio = 1'b0;
        @(posedge clk);
        #1;

        // Zero wait states, CPU_MIO held high across four transactions
        txA = '{32'h0, 32'h4, 32'h0, 32'h4};
        txD = '{32'hC0DE_0001, 32'hC0DE_0002, 32'h0, 32'h0};
        txW = '{1'b1, 1'b1, 1'b0, 1'b0};
        rdv = '{32'h0, 32'h0, 32'h0, 32'h0};
        erv = 4'hF;
        pattern = 8'h00;
        p = 0;
        @(negedge clk);
        cpuMio0 = 1'b1; memW0 = txW[0]; addrIn0 = txA[0]; dataWr0 = txD[0];
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            pattern[i] = ready0;
            if (ready0) begin
                if (p < 4) begin
                    rdv[p] = dataRd0;
                    erv[p] = errO0;
                end
                p++;
                if (p < 4) begin
                    memW0 = txW[p]; addrIn0 = txA[p]; dataWr0 = txD[p];
                end else begin
                    cpuMio0 = 1'b0;
                end
            end
        end
        cpuMio0 = 1'b0;
        checkOutput("w0_ready_pattern", {24'd0, pattern}, 32'h0000_0055);
        checkOutput("w0_pulse_count", 32'(p), 32'd4);
        checkOutput("w0_rd0_data", rdv[2], 32'hC0DE_0001);
        checkOutput("w0_rd4_data", rdv[3], 32'hC0DE_0002);
        checkOutput("w0_err_all", {28'd0, erv}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mio_bus_responder.md
MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning RAM holds 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the number of wait states inserted before each response.
REQ-003 SHALL have parameter PERIPH_BASE, default 32'hF000_0000, meaning the base address of the peripheral region.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 CPU_MIO  input  1  request valid from the CPU; held high until MIO_ready is seen.
REQ-007 mem_w  input  1  1 = write request, 0 = read request; sampled with CPU_MIO.
REQ-008 Addr_in  input  32  byte address of the request.
REQ-009 Data_wr  input  32  write data.
REQ-010 Data_rd  output  32  read data; valid only while MIO_ready=1.
REQ-011 MIO_ready  output  1  one-cycle response strobe.
REQ-012 err  output  1  asserted with MIO_ready when the access was misaligned or unmapped.
REQ-013 led_out  output  16  LED register contents.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
- IDLE -> WAIT when CPU_MIO=1 and WAIT_CYCLES>0.
- IDLE -> RESP when CPU_MIO=1 and WAIT_CYCLES=0.
- WAIT -> RESP when the wait counter reaches WAIT_CYCLES-1.
- RESP -> IDLE unconditionally.
REQ-015 SHALL latch Addr_in, Data_wr and mem_w on the accepting edge (leaving IDLE); later changes to these inputs SHALL be ignored for that transaction.
REQ-016 SHALL ignore CPU_MIO outside IDLE; CPU_MIO=1 sampled in IDLE on the cycle after RESP SHALL start a new transaction.
REQ-017 If CPU_MIO is sampled high in cycle 0, MIO_ready SHALL be high in cycle 1+WAIT_CYCLES for exactly one cycle.
REQ-018 The wait counter SHALL be 4 bits, clear to 0 on accept, and increment once per WAIT cycle.
REQ-019 Address map, applied to the latched address:
- RAM: Addr < 4*2^DEPTH_LOG2; word index = Addr[DEPTH_LOG2+1:2].
- LED: PERIPH_BASE+0x0; read/write; bits [15:0] are used, and reads return the upper 16 bits as zero.
- CNT: PERIPH_BASE+0x4; read-only free-running 32-bit cycle counter that wraps from FFFF_FFFF to 0. Writes are ignored and are not an error.
- Everything else is unmapped.
REQ-020 A write SHALL commit on the edge entering RESP; a read SHALL present data combinationally from storage while in RESP.
REQ-021 If latched Addr[1:0]!=0, the access SHALL assert err in RESP, drive Data_rd=0, and perform no write.
REQ-022 An unmapped access SHALL assert err in RESP, drive Data_rd=0, and perform no write.
REQ-023 Outside RESP, Data_rd SHALL be 0 and err SHALL be 0.
REQ-024 A CNT read SHALL return the counter value sampled on the edge entering RESP.
REQ-025 RAM addressing SHALL have no wrap-around: an address at or above the RAM size that is not a peripheral address is unmapped.

Reset
REQ-026 While reset=0 on a rising edge:
- FSM -> IDLE.
- wait counter = 0, cycle counter = 0, led_out = 0.
- MIO_ready = 0, err = 0, Data_rd = 0.
REQ-027 A reset asserted during WAIT or RESP SHALL abort the transaction, with no write committed if reset is sampled on the committing edge.
REQ-028 RAM contents SHALL NOT be reset.
REQ-029 CPU_MIO sampled in the same cycle as reset=0 SHALL be ignored.

Verification
REQ-030 With WAIT_CYCLES=1: write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010. Required: MIO_ready 2 cycles after each accept; the read returns 0x1234_5678 with err=0.
REQ-031 Write 0xABCD_BEEF to PERIPH_BASE. Required: led_out=0xBEEF after the RESP edge; a read of PERIPH_BASE returns 0x0000_BEEF.
REQ-032 Read 0x0000_0102 (misaligned), then write 0x0000_0200 with DEPTH_LOG2=6 (unmapped). Required: err=1 with Data_rd=0 on both; RAM word 0 remains unchanged.
REQ-033 With WAIT_CYCLES=0: hold CPU_MIO high continuously across reads of 0x0 and 0x4. Required: MIO_ready pulses every 2 cycles, each pulse is one cycle, and there is no double response.
REQ-034 Assert reset=0 during WAIT of a write of 0x5555_5555 to 0x8. Required: no MIO_ready; the RAM word at 0x8 keeps its prior value; led_out=0 and CNT restarts from 0.
REQ-035 Force CNT to 0xFFFF_FFFF via a hierarchical deposit, then read CNT. Required: the counter wraps to 0 on the next edge with no err; Data_rd equals the value sampled on RESP entry.
